// File: rtl/sparse_coo_encoder_if.sv
// Bus bundle between the raster pixel source, the COO encoder and the PE feature inputs.
// The encoder uses the slave view; the surrounding environment uses the master view.
interface sparse_coo_encoder_if #(
  parameter int word_length        = 8,
  parameter int col_length         = 8,
  parameter int double_word_length = 16,
  parameter int max_nz             = 784
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic signed [word_length-1:0]        in_pixel;
  logic [double_word_length-1:0]        in_channel;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [double_word_length-1:0]        out_channel;
  logic [double_word_length-1:0]        feature_valid_num;
  logic [max_nz*word_length-1:0]        feature_value;
  logic [max_nz*col_length-1:0]         feature_cols;
  logic [max_nz*col_length-1:0]         feature_rows;

  modport slave (
    input  in_valid, in_pixel, in_channel, out_ready,
    output in_ready, out_valid, out_channel, feature_valid_num,
           feature_value, feature_cols, feature_rows
  );

  modport master (
    output in_valid, in_pixel, in_channel, out_ready,
    input  in_ready, out_valid, out_channel, feature_valid_num,
           feature_value, feature_cols, feature_rows
  );
endinterface

// File: rtl/sparse_coo_encoder.sv
// Dense raster image stream -> sparse COO frame (value/col/row vectors + non-zero count).
// Non-zero pixels are packed from entry 0 in scan order; zeros are dropped. The finished
// frame is held until the consumer takes it, then all entries are cleared for the next one.
module sparse_coo_encoder #(
  parameter int word_length        = 8,
  parameter int col_length         = 8,
  parameter int double_word_length = 16,
  parameter int image_size         = 28,
  parameter int max_nz             = 784
) (
  input  logic              clk,
  input  logic              rst,
  sparse_coo_encoder_if.slave bus
);

  localparam int IDX_W = (max_nz > 1) ? $clog2(max_nz) : 1;
  localparam logic [col_length-1:0] LAST = col_length'(image_size - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                          state;
  state_t                          state_nxt;

  logic                            accept;
  logic                            last_pix;
  logic                            wr_en;
  logic                            release_frame;
  logic [col_length-1:0]           row_cnt;
  logic [col_length-1:0]           col_cnt;
  logic [double_word_length-1:0]   nz_cnt;
  logic [double_word_length-1:0]   channel_q;
  logic [IDX_W-1:0]                wr_idx;

  logic signed [word_length-1:0]   val_mem [max_nz];
  logic [col_length-1:0]           col_mem [max_nz];
  logic [col_length-1:0]           row_mem [max_nz];

  assign accept        = bus.in_valid & bus.in_ready;
  assign last_pix      = (row_cnt == LAST) && (col_cnt == LAST);
  assign wr_en         = accept && (bus.in_pixel != '0);
  assign release_frame = (state == DONE) && bus.out_ready;
  // Entry slot for the next non-zero; nz_cnt never exceeds max_nz so the low bits suffice.
  assign wr_idx        = nz_cnt[IDX_W-1:0];

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a frame ends on the beat at the last raster position; DONE waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_pix ? DONE : SCAN;
      SCAN:    if (accept && last_pix) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is also held low while reset is asserted.
  always_comb begin
    bus.in_ready  = rst && (state != DONE);
    bus.out_valid = (state == DONE);
  end

  // Raster position, non-zero count and channel capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      nz_cnt    <= '0;
      channel_q <= '0;
    end else if (release_frame) begin
      row_cnt <= '0;
      col_cnt <= '0;
      nz_cnt  <= '0;
    end else if (accept) begin
      if (state == IDLE) channel_q <= bus.in_channel;
      if (wr_en) nz_cnt <= nz_cnt + 1'b1;
      if (last_pix) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (col_cnt == LAST) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Entry storage: written densely on non-zero beats, wiped on reset and on frame hand-off
  // so unused entries always read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < max_nz; k++) begin
        val_mem[k] <= '0;
        col_mem[k] <= '0;
        row_mem[k] <= '0;
      end
    end else if (release_frame) begin
      for (int k = 0; k < max_nz; k++) begin
        val_mem[k] <= '0;
        col_mem[k] <= '0;
        row_mem[k] <= '0;
      end
    end else if (wr_en) begin
      val_mem[wr_idx] <= bus.in_pixel;
      col_mem[wr_idx] <= col_cnt;
      row_mem[wr_idx] <= row_cnt;
    end
  end

  assign bus.feature_valid_num = nz_cnt;
  assign bus.out_channel       = channel_q;

  for (genvar k = 0; k < max_nz; k++) begin : g_pack
    assign bus.feature_value[(k+1)*word_length-1 -: word_length] = val_mem[k];
    assign bus.feature_cols[(k+1)*col_length-1 -: col_length]   = col_mem[k];
    assign bus.feature_rows[(k+1)*col_length-1 -: col_length]   = row_mem[k];
  end

endmodule

// File: tb/tb_sparse_coo_encoder.sv
// Bench for sparse_coo_encoder: directed frames, expected frames queued at issue time and
// compared by an independent monitor whenever the encoder hands a frame over.
module tb_sparse_coo_encoder;

  localparam int WL   = 8;
  localparam int CL   = 8;
  localparam int DWL  = 16;
  localparam int IS   = 28;
  localparam int NZ   = 784;
  localparam int NPIX = IS * IS;

  typedef struct {
    logic [DWL-1:0]   ch;
    logic [DWL-1:0]   num;
    logic [NZ*WL-1:0] val;
    logic [NZ*CL-1:0] col;
    logic [NZ*CL-1:0] row;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sparse_coo_encoder_if #(.word_length(WL), .col_length(CL), .double_word_length(DWL),
                          .max_nz(NZ)) bus ();

  sparse_coo_encoder #(.word_length(WL), .col_length(CL), .double_word_length(DWL),
                       .image_size(IS), .max_nz(NZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_t                exp_q[$];
  frame_t                mon_f;
  frame_t                f;
  int                    checks   = 0;
  int                    failures = 0;
  logic signed [WL-1:0]  pix [NPIX];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_bus(input string name, input logic [NZ*8-1:0] act,
                           input logic [NZ*8-1:0] req);
    int first;
    checks++;
    if (act !== req) begin
      first = 0;
      for (int k = NZ - 1; k >= 0; k--)
        if (act[k*8 +: 8] !== req[k*8 +: 8]) first = k;
      failures++;
      $display("FAIL %s entry=%0d actual=%h required=%h at %0t", name, first,
               act[first*8 +: 8], req[first*8 +: 8], $time);
    end
  endtask

  function automatic frame_t empty_frame(input logic [DWL-1:0] ch);
    frame_t e;
    e.ch  = ch;
    e.num = '0;
    e.val = '0;
    e.col = '0;
    e.row = '0;
    return e;
  endfunction

  // Reference packing of the current pix[] image, used for the dense frame.
  function automatic frame_t model(input logic [DWL-1:0] ch);
    frame_t e;
    int n;
    e = empty_frame(ch);
    n = 0;
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        if (pix[r*IS + c] != 0) begin
          e.val[n*WL +: WL] = pix[r*IS + c];
          e.col[n*CL +: CL] = CL'(c);
          e.row[n*CL +: CL] = CL'(r);
          n++;
        end
    e.num = DWL'(n);
    return e;
  endfunction

  // Single -7 at row 3 col 5, hand-packed.
  function automatic frame_t single_frame(input logic [DWL-1:0] ch);
    frame_t e;
    e = empty_frame(ch);
    e.num        = 16'd1;
    e.val[7:0]   = 8'hF9;
    e.col[7:0]   = 8'd5;
    e.row[7:0]   = 8'd3;
    return e;
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < NPIX; i++) pix[i] = '0;
  endtask

  task automatic fill_single();
    fill_zero();
    pix[3*IS + 5] = -8'sd7;
  endtask

  // Drive nbeats pixels; channel is only correct on the first beat so a late capture shows up.
  task automatic send_frame(input logic [DWL-1:0] ch, input bit gaps, input int nbeats);
    int n;
    int g;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        g = 0;
        while (g < 4 && $urandom_range(0, 1) == 1) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
          g++;
        end
      end
      bus.in_valid   = 1'b1;
      bus.in_pixel   = pix[i];
      bus.in_channel = (i == 0) ? ch : ~ch;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 50) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout beat=%0d actual=0 required=1", i);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Called right after the last beat's edge: frame must already be presented, then hand it off.
  task automatic finish_frame(input string tag);
    check_val({tag, "_latency_out_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_val({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_post_valid_num"}, 32'(bus.feature_valid_num), 32'd0);
    check_val({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_bus({tag, "_post_value_clear"}, bus.feature_value, '0);
  endtask

  // Monitor: compare each handed-over frame against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=frame required=none at %0t", $time);
        end else begin
          mon_f = exp_q.pop_front();
          check_val("out_channel", 32'(bus.out_channel), 32'(mon_f.ch));
          check_val("feature_valid_num", 32'(bus.feature_valid_num), 32'(mon_f.num));
          check_bus("feature_value", bus.feature_value, mon_f.val);
          check_bus("feature_cols", bus.feature_cols, mon_f.col);
          check_bus("feature_rows", bus.feature_rows, mon_f.row);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_pixel   = '0;
    bus.in_channel = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_valid_num", 32'(bus.feature_valid_num), 32'd0);
    check_val("rst_out_channel", 32'(bus.out_channel), 32'd0);
    check_bus("rst_value", bus.feature_value, '0);
    check_bus("rst_cols", bus.feature_cols, '0);
    check_bus("rst_rows", bus.feature_rows, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // All-zero frame, channel 3.
    fill_zero();
    exp_q.push_back(empty_frame(16'd3));
    send_frame(16'd3, 1'b0, NPIX);
    finish_frame("t1");

    // Single -7 at (3,5), channel 5.
    fill_single();
    exp_q.push_back(single_frame(16'd5));
    send_frame(16'd5, 1'b0, NPIX);
    finish_frame("t2");

    // Dense frame, channel 7; last entry hand-computed.
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        pix[r*IS + c] = WL'((r*IS + c) % 127 + 1);
    exp_q.push_back(model(16'd7));
    send_frame(16'd7, 1'b0, NPIX);
    check_val("t3_valid_num", 32'(bus.feature_valid_num), 32'd784);
    check_val("t3_last_value", 32'(bus.feature_value[783*WL +: WL]), 32'd22);
    check_val("t3_last_col", 32'(bus.feature_cols[783*CL +: CL]), 32'd27);
    check_val("t3_last_row", 32'(bus.feature_rows[783*CL +: CL]), 32'd27);
    check_val("t3_first_value", 32'(bus.feature_value[WL-1:0]), 32'd1);
    finish_frame("t3");

    // Back-pressure in DONE with in_valid held high.
    fill_single();
    exp_q.push_back(single_frame(16'd6));
    send_frame(16'd6, 1'b0, NPIX);
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'sd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("t4_hold_valid_num", 32'(bus.feature_valid_num), 32'd1);
      check_val("t4_hold_value0", 32'(bus.feature_value[7:0]), 32'hF9);
    end
    finish_frame("t4");

    // Same single-pixel frame with random in_valid gaps.
    fill_single();
    exp_q.push_back(single_frame(16'd8));
    send_frame(16'd8, 1'b1, NPIX);
    finish_frame("t5");

    // Reset after 400 beats (entry already written), then a clean single-pixel frame.
    fill_single();
    send_frame(16'd2, 1'b0, 400);
    rst = 1'b0;
    #1;
    check_val("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("t6_rst_valid_num", 32'(bus.feature_valid_num), 32'd0);
    check_bus("t6_rst_value", bus.feature_value, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(single_frame(16'd5));
    send_frame(16'd5, 1'b0, NPIX);
    finish_frame("t6");

    repeat (3) @(posedge clk);
    #1;
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
